rtm_wr_arb: RTL and testbench

- Round-robin, burst-locked arbiter sharing the single set of RTM write ports among N_REQ write-back sources (Add write-back, conv/pool write-back, DMA loader).
- Each source presents full-width RTM write beats with a valid/ready handshake and a last flag. The arbiter grants one source for a whole burst and forwards its beats to the RTM write ports through one register stage.

---
 rtl/rtm_wr_arb.sv | 159 +++++++++++++++
 tb/tb_rtm_wr_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtm_wr_arb.sv
// rtm_wr_arb: round-robin, burst-locked arbiter that shares the RTM write
// ports among N_REQ write-back sources. A source is granted for a whole burst
// (until its last beat is accepted); accepted beats reach the RTM write ports
// through one register stage.
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   req_vld      per-requester beat valid
//   req_rdy      per-requester beat accept (combinational from state)
//   req_last     per-requester final-beat flag
//   req_en       per-requester, per-slice write enable  (N_REQ*S)
//   req_addr     per-requester, per-slice row address   (N_REQ*S*AW)
//   req_din      per-requester beat data                (N_REQ*S*R*8)
//   rtm_wr_vld   registered write strobe
//   rtm_wr_en    registered per-slice enable
//   rtm_wr_addr  registered per-slice address
//   rtm_din      registered write data
//   grant_id     current / last granted requester
//   busy         high while a burst is in progress
module rtm_wr_arb #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned S         = 8,
  parameter int unsigned R         = 32,
  parameter int unsigned RTM_DEPTH = 4096,
  localparam int unsigned AW = $clog2(RTM_DEPTH),
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned DW = S * R * 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*S-1:0]      req_en,
  input  logic [N_REQ*S*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]     req_din,
  output logic                    rtm_wr_vld,
  output logic [S-1:0]            rtm_wr_en,
  output logic [S*AW-1:0]         rtm_wr_addr,
  output logic [DW-1:0]           rtm_din,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   winner;
  logic            win_found;
  logic [GW:0]     cand;
  logic            accept;

  logic            sel_vld;
  logic            sel_last;
  logic [S-1:0]    sel_en;
  logic [S*AW-1:0] sel_addr;
  logic [DW-1:0]   sel_din;

  assign grant_id = grant_q;

  // Route the granted requester's beat fields.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_en   = '0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
        sel_en   = req_en[i*S +: S];
        sel_addr = req_addr[i*S*AW +: S*AW];
        sel_din  = req_din[i*DW +: DW];
      end
    end
  end

  // First requesting index at or after rr_ptr, wrapping at N_REQ-1 -> 0.
  always_comb begin
    winner    = rr_ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) begin
        cand = cand - (GW+1)'(N_REQ);
      end
      if (!win_found && req_vld[cand[GW-1:0]]) begin
        winner    = cand[GW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Next-state, grant and ready generation.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    req_rdy  = '0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = winner;
          state_d = BURST;
        end
      end
      BURST: begin
        req_rdy = N_REQ'(1) << grant_q;
        accept  = sel_vld;
        if (sel_vld && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, round-robin pointer and grant registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy     <= (state_d == BURST);
    end
  end

  // Output stage; address and data hold between accepted beats.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rtm_wr_vld  <= 1'b0;
      rtm_wr_en   <= '0;
      rtm_wr_addr <= '0;
      rtm_din     <= '0;
    end else begin
      rtm_wr_vld <= accept;
      rtm_wr_en  <= accept ? sel_en : '0;
      if (accept) begin
        rtm_wr_addr <= sel_addr;
        rtm_din     <= sel_din;
      end
    end
  end

endmodule

// File: tb/tb_rtm_wr_arb.sv
// tb_rtm_wr_arb: scoreboard bench for rtm_wr_arb. Scripted requester sources
// present beats; directed tests push the hand-ordered expected writes into a
// queue that a negedge monitor pops on every rtm_wr_vld.
module tb_rtm_wr_arb;

  localparam int unsigned N  = 3;
  localparam int unsigned S  = 8;
  localparam int unsigned R  = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned GW = 2;
  localparam int unsigned DW = S * R * 8;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      req_last;
  logic [N*S-1:0]    req_en;
  logic [N*S*AW-1:0] req_addr;
  logic [N*DW-1:0]   req_din;
  logic              rtm_wr_vld;
  logic [S-1:0]      rtm_wr_en;
  logic [S*AW-1:0]   rtm_wr_addr;
  logic [DW-1:0]     rtm_din;
  logic [GW-1:0]     grant_id;
  logic              busy;

  rtm_wr_arb #(.N_REQ(N), .S(S), .R(R), .RTM_DEPTH(4096)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_last(req_last),
    .req_en(req_en), .req_addr(req_addr), .req_din(req_din),
    .rtm_wr_vld(rtm_wr_vld), .rtm_wr_en(rtm_wr_en),
    .rtm_wr_addr(rtm_wr_addr), .rtm_din(rtm_din),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    bit          gap;
    bit          last;
    logic [7:0]  en;
    logic [11:0] addr;
  } beat_t;

  typedef struct {
    int          id;
    logic [11:0] addr;
    logic [7:0]  en;
    int          dcyc;
    bit          last;
  } exp_t;

  beat_t srcq [N][$];
  exp_t  expq [$];
  logic [N-1:0] pres;
  logic [N-1:0] acc_s;
  bit    mon_en;
  int    nchk, nerr, nwr, cyc, last_wr;
  logic [11:0] last_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_din(input logic [11:0] a, input int id);
    logic [DW-1:0] d;
    for (int b = 0; b < int'(S*R); b++) d[b*8 +: 8] = 8'(int'(a) + id*37 + b);
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic src(input int id, input bit gap, input bit last,
                     input logic [7:0] en, input logic [11:0] addr);
    beat_t b;
    b.gap = gap; b.last = last; b.en = en; b.addr = addr;
    srcq[id].push_back(b);
  endtask

  task automatic expect_wr(input int id, input logic [11:0] addr, input logic [7:0] en,
                           input int dcyc, input bit last);
    exp_t e;
    e.id = id; e.addr = addr; e.en = en; e.dcyc = dcyc; e.last = last;
    expq.push_back(e);
  endtask

  // Requester sources: acceptance sampled just before the edge, new beat driven after it.
  initial begin
    beat_t b;
    req_vld = '0; req_last = '0; req_en = '0; req_din = '0;
    req_addr = '0; pres = '0; acc_s = '0;
    forever begin
      @(negedge clk); #4;
      acc_s = req_vld & req_rdy & {N{rstn}};
      @(posedge clk); #1;
      for (int i = 0; i < int'(N); i++) begin
        if (pres[i] && srcq[i].size() > 0 && (acc_s[i] || srcq[i][0].gap))
          void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          b = srcq[i][0];
          pres[i] = 1'b1;
          req_vld[i] = !b.gap;
          req_last[i] = b.last;
          req_en[i*S +: S] = b.en;
          for (int s = 0; s < int'(S); s++) req_addr[(i*S+s)*AW +: AW] = b.addr;
          req_din[i*DW +: DW] = mk_din(b.addr, i);
        end else begin
          pres[i] = 1'b0;
          req_vld[i] = 1'b0;
          req_last[i] = 1'b0;
          req_en[i*S +: S] = '0;
          for (int s = 0; s < int'(S); s++) req_addr[(i*S+s)*AW +: AW] = 12'hABC;
          req_din[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor: scoreboard compare on every write, ready/hold invariants otherwise.
  initial begin
    exp_t e;
    logic [N-1:0] er;
    last_addr = '0; nwr = 0; cyc = 0; last_wr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (!rstn) last_addr = '0;
        er = busy ? (3'b001 << grant_id) : 3'b000;
        chk("rdy_vs_grant", 64'(req_rdy), 64'(er));
        if (rtm_wr_vld) begin
          nwr++;
          if (expq.size() == 0) begin
            chk("unexpected_wr", 64'(expq.size()), 64'(1));
          end else begin
            e = expq.pop_front();
            chk("wr_grant", 64'(grant_id), 64'(e.id));
            chk("wr_en", 64'(rtm_wr_en), 64'(e.en));
            chk("wr_addr0", 64'(rtm_wr_addr[AW-1:0]), 64'(e.addr));
            chk("wr_addr_all", 64'(rtm_wr_addr == {S{e.addr}}), 64'(1));
            chk("wr_din", 64'(rtm_din == mk_din(e.addr, e.id)), 64'(1));
            chk("wr_busy", 64'(busy), 64'(!e.last));
            if (e.dcyc != 0) chk("wr_spacing", 64'(cyc - last_wr), 64'(e.dcyc));
          end
          last_wr = cyc;
          last_addr = rtm_wr_addr[AW-1:0];
        end else begin
          chk("idle_en", 64'(rtm_wr_en), 64'(0));
          chk("hold_addr", 64'(rtm_wr_addr == {S{last_addr}}), 64'(1));
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || pres != '0 || srcq[0].size() != 0 ||
            srcq[1].size() != 0 || srcq[2].size() != 0) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    chk({name, "_drain"}, 64'(expq.size() + srcq[0].size() + srcq[1].size() + srcq[2].size()), 64'(0));
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    logic [11:0] a;
    int d;
    nchk = 0; nerr = 0; mon_en = 0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_vld", 64'(rtm_wr_vld), 64'(0));
    chk("rst_en", 64'(rtm_wr_en), 64'(0));
    chk("rst_addr", 64'(rtm_wr_addr == '0), 64'(1));
    chk("rst_din", 64'(rtm_din == '0), 64'(1));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_rdy", 64'(req_rdy), 64'(0));
    rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk); #1;

    // Single requester: req1 four beats 10..13
    for (int k = 0; k < 4; k++) begin
      src(1, 0, k == 3, 8'hFF, 12'(10 + k));
      expect_wr(1, 12'(10 + k), 8'hFF, (k == 0) ? 0 : 1, k == 3);
    end
    drain("single");
    chk("single_busy_end", 64'(busy), 64'(0));

    // Enable masking on req2 (also leaves rr_ptr at 0)
    src(2, 0, 0, 8'b0000_0101, 12'd20);
    src(2, 0, 1, 8'b0000_0000, 12'd21);
    expect_wr(2, 12'd20, 8'b0000_0101, 0, 0);
    expect_wr(2, 12'd21, 8'b0000_0000, 1, 1);
    drain("mask");

    // Round robin: three requesters, two 2-beat bursts each
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        a = 12'(12'h100 + r*12'h40 + i*12'h10);
        src(i, 0, 0, 8'hF0, a);
        src(i, 0, 1, 8'h0F, a + 12'd1);
        d = (r == 0 && i == 0) ? 0 : 2;
        expect_wr(i, a, 8'hF0, d, 0);
        expect_wr(i, a + 12'd1, 8'h0F, 1, 1);
      end
    end
    drain("rr");

    // Wrap of rr_ptr after grant 2: order 0, 2, 0
    src(0, 0, 1, 8'h11, 12'h200);
    src(0, 0, 1, 8'h22, 12'h201);
    src(2, 0, 1, 8'h33, 12'h210);
    expect_wr(0, 12'h200, 8'h11, 0, 1);
    expect_wr(2, 12'h210, 8'h33, 2, 1);
    expect_wr(0, 12'h201, 8'h22, 2, 1);
    drain("wrap");

    // Bubble inside a req2 burst while req0 waits (rr_ptr = 1)
    src(2, 0, 0, 8'hAA, 12'h040);
    src(2, 1, 0, 8'h00, 12'h000);
    src(2, 1, 0, 8'h00, 12'h000);
    src(2, 0, 1, 8'h55, 12'h041);
    src(0, 0, 1, 8'h77, 12'h050);
    expect_wr(2, 12'h040, 8'hAA, 0, 0);
    expect_wr(2, 12'h041, 8'h55, 3, 1);
    expect_wr(0, 12'h050, 8'h77, 2, 1);
    drain("bubble");

    // Reset mid-burst: req1 burst then req0 burst cut after two beats
    base = nwr;
    src(1, 0, 0, 8'h01, 12'h060);
    src(1, 0, 1, 8'h02, 12'h061);
    for (int k = 0; k < 4; k++) src(0, 0, k == 3, 8'h03, 12'(12'h070 + k));
    expect_wr(1, 12'h060, 8'h01, 0, 0);
    expect_wr(1, 12'h061, 8'h02, 1, 1);
    expect_wr(0, 12'h070, 8'h03, 2, 0);
    expect_wr(0, 12'h071, 8'h03, 1, 0);
    n = 0;
    while (nwr < base + 4 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_wait", 64'(nwr - base), 64'(4));
    rstn = 1'b0;
    srcq[0].delete();
    @(negedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_vld", 64'(rtm_wr_vld), 64'(0));
    chk("midrst_rdy", 64'(req_rdy), 64'(0));
    chk("midrst_en", 64'(rtm_wr_en), 64'(0));
    chk("midrst_addr", 64'(rtm_wr_addr == '0), 64'(1));
    chk("midrst_pending", 64'(expq.size()), 64'(0));
    rstn = 1'b1;
    // rr_ptr back at 0: req1 wins over req2
    src(1, 0, 1, 8'h0C, 12'h080);
    src(2, 0, 1, 8'hC0, 12'h090);
    expect_wr(1, 12'h080, 8'h0C, 0, 1);
    expect_wr(2, 12'h090, 8'hC0, 2, 1);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
